// File: rtl/tx_uart.sv
// 8N1 UART transmitter: byte FIFO behind a valid/ready handshake, frames
// serialized LSB-first on a registered o_Tx with no idle gap between frames.
module tx_uart #(
  parameter int CLK_RATE   = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] sel_baud,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Tx,
  output logic       o_Busy
);

  localparam int DIV_9600   = CLK_RATE / 9600;
  localparam int DIV_19200  = CLK_RATE / 19200;
  localparam int DIV_38400  = CLK_RATE / 38400;
  localparam int DIV_57600  = CLK_RATE / 57600;
  localparam int DIV_115200 = CLK_RATE / 115200;
  localparam int BW = $clog2(DIV_9600 + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Same code-to-rate table as rx_uart; unused codes fall back to 9600.
  function automatic logic [BW-1:0] div_for(input logic [3:0] sel);
    case (sel)
      4'd1:    div_for = BW'(DIV_19200);
      4'd2:    div_for = BW'(DIV_38400);
      4'd3:    div_for = BW'(DIV_57600);
      4'd4:    div_for = BW'(DIV_115200);
      default: div_for = BW'(DIV_9600);
    endcase
  endfunction

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic [BW-1:0]   r_baud_cnt;
  logic [BW-1:0]   r_div;
  logic            r_tx;
  logic            w_next_tx;
  logic            w_pop;
  logic            w_push;
  logic            w_baud_done;
  logic            w_empty;
  logic            w_full;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  assign w_empty     = (r_count == CW'(0));
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = i_Valid && !w_full;
  assign w_baud_done = (r_baud_cnt == (r_div - BW'(1)));

  assign o_Ready = !w_full;
  assign o_Tx    = r_tx;
  assign o_Busy  = (r_state != S_IDLE) || !w_empty;

  // Next-state, next line level and FIFO pop request.
  always_comb begin
    w_next_state = r_state;
    w_next_tx    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_tx    = 1'b0;
          w_next_state = S_START;
        end else begin
          w_next_tx    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_next_tx    = r_shift[0];
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_START;
        end
      end
      S_DATA: begin
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
          w_next_tx    = 1'b1;
          w_next_state = S_STOP;
        end else if (w_baud_done) begin
          w_next_tx    = r_shift[1];
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        if (w_baud_done && !w_empty) begin
          w_pop        = 1'b1;
          w_next_tx    = 1'b0;
          w_next_state = S_START;
        end else if (w_baud_done) begin
          w_next_tx    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_STOP;
        end
      end
      default: begin
        w_next_tx    = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM state, line register, shift register and baud/bit counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_baud_cnt <= BW'(0);
      r_div      <= div_for(4'd0);
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_next_tx;
      if (w_pop) begin
        r_shift    <= r_mem[r_rptr];
        r_div      <= div_for(sel_baud);
        r_baud_cnt <= BW'(0);
        r_bit_idx  <= 3'd0;
      end else if ((r_state != S_IDLE) && w_baud_done) begin
        r_baud_cnt <= BW'(0);
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else if (r_state != S_IDLE) begin
        r_baud_cnt <= r_baud_cnt + BW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a push while full is dropped even on a pop edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_Data;
  end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: a frame-level model (byte queue + frame start time) predicts
// o_Tx/o_Ready/o_Busy every cycle; directed scenarios add literal expectations.
module tb_tx_uart;

  localparam int DEPTH = 4;

  logic       clk;
  logic       i_rst;
  logic [3:0] sel_baud;
  logic [7:0] i_Data;
  logic       i_Valid;
  logic       o_Ready;
  logic       o_Tx;
  logic       o_Busy;

  int checks = 0;
  int errors = 0;

  tx_uart #(.CLK_RATE(1000000), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .sel_baud(sel_baud), .i_Data(i_Data),
    .i_Valid(i_Valid), .o_Ready(o_Ready), .o_Tx(o_Tx), .o_Busy(o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [3:0] code);
    int baud;
    case (code)
      4'd1:    baud = 19200;
      4'd2:    baud = 38400;
      4'd3:    baud = 57600;
      4'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return 1000000 / baud;
  endfunction

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         m_live = 0;
  bit         m_active = 0;
  int         m_start = 0;
  int         m_div = 1;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] mq[$];

  always @(posedge clk) begin
    bit ended;
    bit pre_full;
    cyc++;
    if (i_rst) begin
      mq.delete();
      m_active = 0;
      m_live   = 1;
    end else begin
      pre_full = (mq.size() == DEPTH);
      ended    = m_active && (cyc == m_start + 10 * m_div);
      if ((!m_active || ended) && mq.size() != 0) begin
        m_byte   = mq.pop_front();
        m_start  = cyc;
        m_div    = div_of(sel_baud);
        m_active = 1;
      end else if (ended) begin
        m_active = 0;
      end
      if (i_Valid && !pre_full) mq.push_back(i_Data);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (cyc - m_start) / m_div;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_tx", o_Tx, exp_tx());
      chk("model_ready", o_Ready, mq.size() != DEPTH);
      chk("model_busy", o_Busy, m_active || (mq.size() != 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b, output int e);
    i_Valid = 1'b1;
    i_Data  = b;
    @(negedge clk);
    e       = cyc;
    i_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (o_Busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 20000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, n2, e;
    int tr;
    logic prev;
    logic [9:0] lv;
    i_rst = 1'b1; sel_baud = 4'd0; i_Data = 8'd0; i_Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    chk("rst_tx", o_Tx, 1);
    chk("rst_ready", o_Ready, 1);
    chk("rst_busy", o_Busy, 0);

    // 'A' at 9600: levels 0,1,0,0,0,0,0,1,0,1 (index 0 first), 104 clocks each
    lv = 10'b10_1000_0010;
    wr(8'h41, n);
    for (int k = 0; k < 10; k++) begin
      wait_edge(n + 1 + k * 104 + 50);
      chk("A_level", o_Tx, lv[k]);
    end
    wait_edge(n + 1040);
    chk("A_busy_last", o_Busy, 1);
    wait_edge(n + 1041);
    chk("A_busy_drop", o_Busy, 0);
    repeat (5) @(negedge clk);

    // "ABCDE" back to back, then a held 6th write
    wr(8'h41, n); wr(8'h42, e); wr(8'h43, e); wr(8'h44, e); wr(8'h45, e);
    chk("five_full", o_Ready, 0);
    i_Valid = 1'b1; i_Data = 8'h46;
    wait_edge(n + 1040);
    chk("held_full", o_Ready, 0);
    chk("A_stop_end", o_Tx, 1);
    @(negedge clk);
    chk("B_start_nogap", o_Tx, 0);
    chk("held_not_taken", o_Ready, 1);
    @(negedge clk);
    i_Valid = 1'b0;
    chk("held_accepted", o_Ready, 0);
    wait_idle();

    // 0xFF at 115200 then at code 9 (falls back to 9600)
    sel_baud = 4'd4;
    wr(8'hFF, n);
    wait_edge(n + 8);  chk("ff4_start", o_Tx, 0);
    wait_edge(n + 9);  chk("ff4_bit0", o_Tx, 1);
    wait_edge(n + 80); chk("ff4_busy", o_Busy, 1);
    wait_edge(n + 81); chk("ff4_done", o_Busy, 0);
    sel_baud = 4'd9;
    wr(8'hFF, n);
    wait_edge(n + 104); chk("ff9_start", o_Tx, 0);
    wait_edge(n + 105); chk("ff9_bit0", o_Tx, 1);
    wait_idle();

    // baud change during data bit 3 of a queued pair
    sel_baud = 4'd0;
    wr(8'h3C, n); wr(8'h5B, e);
    wait_edge(n + 1 + 4 * 104 + 10);
    sel_baud = 4'd4;
    wait_edge(n + 1 + 4 * 104 + 60);  chk("chg_bit3", o_Tx, 1);
    wait_edge(n + 1 + 9 * 104 + 50);  chk("chg_stop", o_Tx, 1);
    wait_edge(n + 1040);              chk("chg_stop_end", o_Tx, 1);
    wait_edge(n + 1041);              chk("chg_b2_start", o_Tx, 0);
    wait_edge(n + 1048);              chk("chg_b2_start_end", o_Tx, 0);
    wait_edge(n + 1049);              chk("chg_b2_bit0", o_Tx, 1);
    wait_idle();

    // reset during data bit 5 with two bytes queued
    sel_baud = 4'd0;
    wr(8'h00, n); wr(8'h77, e); wr(8'h88, e);
    wait_edge(n + 1 + 6 * 104 + 19);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("mid_rst_tx", o_Tx, 1);
    chk("mid_rst_busy", o_Busy, 0);
    chk("mid_rst_ready", o_Ready, 1);
    tr = 0; prev = o_Tx;
    repeat (300) begin
      @(negedge clk);
      if (o_Tx !== prev) tr++;
      prev = o_Tx;
    end
    chk("mid_rst_quiet", tr, 0);

    // push while full on the pop edge is dropped
    wr(8'h11, n); wr(8'h22, e); wr(8'h33, e); wr(8'h44, e); wr(8'h55, e);
    wait_edge(n + 1040);
    i_Valid = 1'b1; i_Data = 8'hEE;
    @(negedge clk);
    i_Valid = 1'b0;
    chk("drop_ready", o_Ready, 1);
    wait_idle();

    // randomized traffic at the fast rates
    for (int c = 0; c < 5000; c++) begin
      i_Valid = ($urandom_range(0, 3) == 0);
      i_Data  = 8'($urandom);
      if ((c % 150) == 0) sel_baud = 4'($urandom_range(3, 4));
      i_rst   = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    i_Valid = 1'b0;
    i_rst   = 1'b0;
    wait_idle();

    n2 = checks;
    $display("Result: errors=%0d of %0d checks", errors, n2);
    $finish;
  end

endmodule
